// File: rtl/memory_access_sequencer.sv
// rtl/memory_access_sequencer.sv - protected load/store sequencer in front of the synchronous data RAM
// Optional feature: define CODE_WRITE_PROTECT_EN to make every store into the code area fault.

module memory_access_sequencer #(
    parameter int unsigned ADDR_WIDTH            = 14,
    parameter int unsigned DATA_WIDTH            = 32,
    parameter int unsigned CODE_AREA_SIZE        = 4096,
    parameter int unsigned PRIVILEGED_STACK_SIZE = 2048,
    parameter int unsigned READ_LATENCY          = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  privilege_mode_flag,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write_enable,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  fault,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(READ_LATENCY) + 1;

    // Region bounds widened to 32 bits so the top RAM word never aliases into a range end.
    localparam logic [31:0] STACK_LO = 32'(CODE_AREA_SIZE);
    localparam logic [31:0] STACK_HI = 32'(CODE_AREA_SIZE + PRIVILEGED_STACK_SIZE);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WAIT,
        CAPTURE,
        RESP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              write_q;
    logic              fault_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [31:0]       addr_ext;
    logic              stack_hit;
    logic              req_fault;
    logic              accept;

    assign addr_ext  = 32'(req_address);
    assign stack_hit = (addr_ext >= STACK_LO) && (addr_ext < STACK_HI);

`ifdef CODE_WRITE_PROTECT_EN
    logic code_hit;
    assign code_hit  = addr_ext < STACK_LO;
    assign req_fault = (!privilege_mode_flag && stack_hit) || (req_write && code_hit);
`else
    assign req_fault = !privilege_mode_flag && stack_hit;
`endif

    assign accept = req_valid && req_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        req_ready        = 1'b0;
        busy             = 1'b1;
        resp_valid       = 1'b0;
        mem_write_enable = 1'b0;
        fault            = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !reset;
                busy      = 1'b0;
                if (req_valid) begin
                    state_next = req_fault ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_write_enable = write_q;
                if (write_q) begin
                    state_next = RESP;
                end else if (READ_LATENCY > 1) begin
                    state_next = WAIT;
                end else begin
                    state_next = CAPTURE;
                end
            end
            WAIT: begin
                if (wait_cnt == CNT_W'(1)) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                fault      = fault_q;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A faulting request leaves the RAM-facing registers untouched so its address never appears.
    always_ff @(posedge clock) begin
        if (reset) begin
            write_q     <= 1'b0;
            fault_q     <= 1'b0;
            wait_cnt    <= '0;
            mem_address <= '0;
            mem_wdata   <= '0;
            resp_rdata  <= '0;
        end else begin
            if (accept) begin
                write_q    <= req_write;
                fault_q    <= req_fault;
                resp_rdata <= '0;
                if (!req_fault) begin
                    mem_address <= req_address;
                    if (req_write) begin
                        mem_wdata <= req_wdata;
                    end
                end
            end
            if (state == ACCESS && !write_q) begin
                wait_cnt <= CNT_W'(READ_LATENCY - 1);
            end else if (state == WAIT && wait_cnt > CNT_W'(1)) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end
            if (state == CAPTURE) begin
                resp_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_sequencer.sv
// tb/tb_memory_access_sequencer.sv - scoreboard bench for memory_access_sequencer with a RAM model

module tb_memory_access_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [13:0] req_address = '0;
    logic [31:0] req_wdata = '0;
    logic        privilege_mode_flag = 1'b0;
    logic [13:0] mem_address;
    logic        mem_write_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        fault;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [32:0] exp_q[$];
    logic [31:0] ram[int];
    logic [31:0] rd_p1 = '0;
    logic [13:0] last_addr = '0;

    memory_access_sequencer dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata),
        .privilege_mode_flag(privilege_mode_flag),
        .mem_address(mem_address), .mem_write_enable(mem_write_enable),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .fault(fault), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ram_read(input logic [13:0] a);
        if (ram.exists(int'(a))) return ram[int'(a)];
        return {16'hA5A5, 2'b00, a};
    endfunction

    // Two-stage read pipe: address at cycle k gives data at cycle k+2.
    always @(posedge clock) begin
        if (mem_write_enable) ram[int'(mem_address)] = mem_wdata;
        rd_p1     <= ram_read(mem_address);
        mem_rdata <= rd_p1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    always @(negedge clock) begin
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 1, 0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("resp_fault", fault, e[32]);
                chk("resp_rdata", resp_rdata, e[31:0]);
            end
        end
    end

    task automatic do_req(input logic wr, input logic [13:0] addr, input logic [31:0] wd,
                          input logic priv, input logic exp_fault, input string tag);
        int resp_cyc = 0;
        int we_cnt = 0;
        int we_cyc = 0;
        int exp_cyc;
        exp_cyc = exp_fault ? 1 : (wr ? 2 : 4);
        @(negedge clock);
        chk({tag, "_ready"}, req_ready, 1);
        req_valid = 1'b1; req_write = wr; req_address = addr;
        req_wdata = wd; privilege_mode_flag = priv;
        exp_q.push_back({exp_fault, (exp_fault || wr) ? 32'h0 : ram_read(addr)});
        @(posedge clock); #1;
        req_valid = 1'b0; req_write = ~wr; req_address = ~addr;
        req_wdata = ~wd; privilege_mode_flag = ~priv;
        for (int k = 1; k <= 12 && resp_cyc == 0; k++) begin
            @(negedge clock);
            if (mem_write_enable) begin we_cnt++; we_cyc = k; end
            if (k == 1) begin
                chk({tag, "_addr_c1"}, mem_address, exp_fault ? last_addr : addr);
                if (wr && !exp_fault) chk({tag, "_wdata_c1"}, mem_wdata, wd);
            end
            if (k <= exp_cyc) chk({tag, "_busy"}, busy, 1);
            if (resp_valid) resp_cyc = k;
        end
        if (!exp_fault) last_addr = addr;
        chk({tag, "_resp_cycle"}, resp_cyc, exp_cyc);
        chk({tag, "_we_count"}, we_cnt, (wr && !exp_fault) ? 1 : 0);
        if (wr && !exp_fault) chk({tag, "_we_cycle"}, we_cyc, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc[$];
        int rsp[$];
        @(negedge clock);
        chk("ready_in_reset", req_ready, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_mem_address", mem_address, 0);
        chk("rst_we", mem_write_enable, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_fault", fault, 0);

        do_req(1'b1, 14'h1800, 32'hDEADBEEF, 1'b0, 1'b0, "st_user");
        do_req(1'b0, 14'h1800, 32'h0,        1'b0, 1'b0, "ld_user");
        chk("ld_user_data_model", ram_read(14'h1800), 32'hDEADBEEF);
        do_req(1'b0, 14'h1000, 32'h0,        1'b0, 1'b1, "ld_stack_user");
        do_req(1'b0, 14'h1000, 32'h0,        1'b1, 1'b0, "ld_stack_priv");
        do_req(1'b0, 14'h17FF, 32'h0,        1'b0, 1'b1, "ld_stack_top_user");
        do_req(1'b0, 14'h0FFF, 32'h0,        1'b0, 1'b0, "ld_code_top_user");
        do_req(1'b1, 14'h1234, 32'h12345678, 1'b0, 1'b1, "st_stack_user");
        do_req(1'b1, 14'h3FFF, 32'hCAFEF00D, 1'b0, 1'b0, "st_top_user");
        do_req(1'b0, 14'h3FFF, 32'h0,        1'b0, 1'b0, "ld_top_user");
`ifdef CODE_WRITE_PROTECT_EN
        do_req(1'b1, 14'h0010, 32'h55AA55AA, 1'b1, 1'b1, "st_code_priv");
        do_req(1'b0, 14'h0010, 32'h0,        1'b0, 1'b0, "ld_code_user");
`else
        do_req(1'b1, 14'h0010, 32'h55AA55AA, 1'b1, 1'b0, "st_code_priv");
        do_req(1'b0, 14'h0010, 32'h0,        1'b0, 1'b0, "ld_code_user");
`endif

        // Back-to-back loads with req_valid held high.
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_address = 14'h0100; privilege_mode_flag = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) @(negedge clock);
            if (resp_valid) rsp.push_back(c);
            if (req_valid && req_ready) begin
                acc.push_back(c);
                exp_q.push_back({1'b0, ram_read(req_address)});
            end
            @(posedge clock); #1;
            if (acc.size() == 1) req_address = 14'h0200;
            if (acc.size() == 2) req_valid = 1'b0;
        end
        chk("b2b_accepts", acc.size(), 2);
        chk("b2b_resps", rsp.size(), 2);
        chk("b2b_acc0", (acc.size() > 0) ? acc[0] : -1, 0);
        chk("b2b_acc1", (acc.size() > 1) ? acc[1] : -1, 5);
        chk("b2b_rsp0", (rsp.size() > 0) ? rsp[0] : -1, 4);
        chk("b2b_rsp1", (rsp.size() > 1) ? rsp[1] : -1, 9);

        // Reset in the middle of a load: its response must never appear.
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_address = 14'h0300; privilege_mode_flag = 1'b0;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mem_address", mem_address, 0);
        chk("mid_rst_we", mem_write_enable, 0);
        chk("mid_rst_wdata", mem_wdata, 0);
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_resp_rdata", resp_rdata, 0);
        chk("mid_rst_fault", fault, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_ready", req_ready, 1);
        repeat (6) @(negedge clock);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
